// File: rtl/pmod_io_ctrl.sv
// pmod_io_ctrl: bus-mapped controller for the 4-button / 4-LED PMOD.
// Buttons are synchronized, debounced and turned into sticky W1C press/release
// events with a maskable level IRQ. Each LED is driven by an 8-bit PWM whose
// duty is double-buffered so a new value only takes effect at period start.
module pmod_io_ctrl #(
  parameter int DEB_CYCLES = 50000,
  parameter int PWM_DIV    = 64
) (
  input  logic        CLK,
  input  logic        RESN,
  input  logic [1:0]  ADDR,
  input  logic        WR,
  input  logic        RD,
  input  logic [3:0]  BE,
  input  logic [31:0] DATAI,
  output logic [31:0] DATAO,
  output logic        ACK,
  input  logic [3:0]  BTN_RAW,
  output logic [3:0]  LED_OUT,
  output logic        IRQ
);

  localparam int DCW = $clog2(DEB_CYCLES);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
  localparam int PCW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PCW-1:0] PRE_LAST = PCW'(PWM_DIV - 1);

  logic [3:0]     sync1_q, sync2_q;
  logic [3:0]     stable_q, stable_d;
  logic [DCW-1:0] deb_cnt_q [4];
  logic [DCW-1:0] deb_cnt_d [4];
  logic [3:0]     accept;
  logic [7:0]     ev_q, ev_d, ev_set, ev_clr;
  logic [7:0]     irqen_q;
  logic           irq_q;
  logic [31:0]    shadow_q, duty_q;
  logic [PCW-1:0] pre_q, pre_d;
  logic [7:0]     phase_q, phase_d;
  logic           started_q;
  logic           tick, load;
  logic [3:0]     led_q, led_d;
  logic           ack_q;
  logic [31:0]    dato_q, rdata;
  logic           wr_ev, wr_irqen, wr_led;

  assign wr_ev    = WR && (ADDR == 2'd1) && BE[0];
  assign wr_irqen = WR && (ADDR == 2'd2) && BE[0];
  assign wr_led   = WR && (ADDR == 2'd3);

  // Per-bit debounce: count while the synced level differs, accept on the last count
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          accept[i]   = 1'b1;
          stable_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Two-flop synchronizer feeding the debouncer state
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= BTN_RAW;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // Press sets [3:0], release sets [7:4]; a set beats a same-cycle clear
  assign ev_set = {accept & stable_q, accept & ~stable_q};
  assign ev_clr = wr_ev ? DATAI[7:0] : 8'h00;
  assign ev_d   = (ev_q & ~ev_clr) | ev_set;

  // Event flags, interrupt mask and registered interrupt level
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      ev_q    <= '0;
      irqen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ev_q  <= ev_d;
      irq_q <= |(ev_q & irqen_q);
      if (wr_irqen) irqen_q <= DATAI[7:0];
    end
  end

  // Read data selection from the current register contents
  always_comb begin
    rdata = '0;
    case (ADDR)
      2'd0: rdata = {28'h0, stable_q};
      2'd1: rdata = {24'h0, ev_q};
      2'd2: rdata = {24'h0, irqen_q};
      2'd3: rdata = shadow_q;
      default: rdata = '0;
    endcase
  end

  // Single-cycle acknowledge; writes (including write+read) return zero
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      ack_q  <= 1'b0;
      dato_q <= '0;
    end else begin
      ack_q  <= WR | RD;
      dato_q <= (RD && !WR) ? rdata : 32'h0;
    end
  end

  assign tick    = (pre_q == PRE_LAST);
  assign load    = tick && ((phase_q == 8'hFF) || !started_q);
  assign pre_d   = tick ? '0 : pre_q + 1'b1;
  assign phase_d = tick ? phase_q + 8'd1 : phase_q;

  // LED comparator: on while duty exceeds the current phase
  always_comb begin
    led_d = '0;
    for (int i = 0; i < 4; i++) led_d[i] = (duty_q[8*i +: 8] > phase_q);
  end

  // PWM timebase, shadow duty written by the bus, active duty loaded at period start
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      pre_q     <= '0;
      phase_q   <= '0;
      started_q <= 1'b0;
      shadow_q  <= '0;
      duty_q    <= '0;
      led_q     <= '0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      if (tick) started_q <= 1'b1;
      if (load) duty_q <= shadow_q;
      for (int i = 0; i < 4; i++)
        if (wr_led && BE[i]) shadow_q[8*i +: 8] <= DATAI[8*i +: 8];
    end
  end

  assign DATAO   = dato_q;
  assign ACK     = ack_q;
  assign LED_OUT = led_q;
  assign IRQ     = irq_q;

endmodule
